// File: rtl/pipeline_control_pkg.sv
// Shared constants and control-bundle types for the pipeline control block.
package pipeline_control_pkg;

  // Major opcodes recognised by the decoder
  localparam logic [6:0] OP_R_TYPE = 7'b0110011;
  localparam logic [6:0] OP_I_LOGIC = 7'b0010011;
  localparam logic [6:0] OP_LOAD = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;

  // Base ALU operation codes, zero-extended to ALU_OP_WIDTH on use
  localparam logic [2:0] ALU_CODE_R = 3'b000;
  localparam logic [2:0] ALU_CODE_I = 3'b001;
  localparam logic [2:0] ALU_CODE_MEM = 3'b010;
  localparam logic [2:0] ALU_CODE_BR = 3'b011;
  localparam logic [2:0] ALU_CODE_LUI = 3'b100;
  localparam logic [2:0] ALU_CODE_AUIPC = 3'b101;
  localparam logic [2:0] ALU_CODE_JUMP = 3'b110;
  localparam logic [2:0] ALU_CODE_NONE = 3'b000;

  // Full decoded control bundle (ALU op carried separately, parameter-width)
  typedef struct packed {
    logic branch;
    logic jump;
    logic mem_read;
    logic mem_write;
    logic reg_write;
    logic mem_to_reg;
    logic alu_src;
  } ctrl_t;

  // Controls still needed once an instruction has left EX
  typedef struct packed {
    logic branch;
    logic jump;
    logic mem_read;
    logic mem_write;
    logic reg_write;
    logic mem_to_reg;
  } mem_ctrl_t;

  // Controls still needed once an instruction has left MEM
  typedef struct packed {
    logic reg_write;
    logic mem_to_reg;
  } wb_ctrl_t;

  localparam ctrl_t CTRL_ZERO = 7'b0000000;
  localparam mem_ctrl_t MEM_CTRL_ZERO = 6'b000000;

endpackage

// File: rtl/pipeline_control_decoder.sv
// Combinational opcode decoder producing the control bundle and ALU op code.
// With ILLEGAL_OP_DETECT_EN defined it also flags opcodes outside the table.
module control_decoder
  import pipeline_control_pkg::*;
#(
  parameter int ALU_OP_WIDTH = 3
) (
  input  logic [6:0]              op_i,
  output ctrl_t                   ctrl_o,
`ifdef ILLEGAL_OP_DETECT_EN
  output logic                    illegal_o,
`endif
  output logic [ALU_OP_WIDTH-1:0] alu_op_o
);

  logic [2:0] alu_code_s;

  // Opcode table lookup; unknown opcodes yield an all-zero bundle
  always_comb begin
    ctrl_o = CTRL_ZERO;
    alu_code_s = ALU_CODE_NONE;
`ifdef ILLEGAL_OP_DETECT_EN
    illegal_o = 1'b0;
`endif
    case (op_i)
      OP_R_TYPE: begin
        ctrl_o.reg_write = 1'b1;
        alu_code_s = ALU_CODE_R;
      end
      OP_I_LOGIC: begin
        ctrl_o.reg_write = 1'b1;
        ctrl_o.alu_src = 1'b1;
        alu_code_s = ALU_CODE_I;
      end
      OP_LOAD: begin
        ctrl_o.mem_read = 1'b1;
        ctrl_o.mem_to_reg = 1'b1;
        ctrl_o.reg_write = 1'b1;
        ctrl_o.alu_src = 1'b1;
        alu_code_s = ALU_CODE_MEM;
      end
      OP_STORE: begin
        ctrl_o.mem_write = 1'b1;
        ctrl_o.alu_src = 1'b1;
        alu_code_s = ALU_CODE_MEM;
      end
      OP_BRANCH: begin
        ctrl_o.branch = 1'b1;
        alu_code_s = ALU_CODE_BR;
      end
      OP_LUI: begin
        ctrl_o.reg_write = 1'b1;
        ctrl_o.alu_src = 1'b1;
        alu_code_s = ALU_CODE_LUI;
      end
      OP_AUIPC: begin
        ctrl_o.reg_write = 1'b1;
        ctrl_o.alu_src = 1'b1;
        alu_code_s = ALU_CODE_AUIPC;
      end
      OP_JAL: begin
        ctrl_o.jump = 1'b1;
        ctrl_o.reg_write = 1'b1;
        alu_code_s = ALU_CODE_JUMP;
      end
      OP_JALR: begin
        ctrl_o.jump = 1'b1;
        ctrl_o.reg_write = 1'b1;
        ctrl_o.alu_src = 1'b1;
        alu_code_s = ALU_CODE_JUMP;
      end
      default: begin
        ctrl_o = CTRL_ZERO;
        alu_code_s = ALU_CODE_NONE;
`ifdef ILLEGAL_OP_DETECT_EN
        illegal_o = 1'b1;
`endif
      end
    endcase
  end

  assign alu_op_o = ALU_OP_WIDTH'(alu_code_s);

endmodule

// File: rtl/pipeline_control.sv
// Pipeline control: decode in ID, carry control through EX/MEM/WB registers,
// detect load-use hazards and apply branch/jump flushes.
// Optional feature macro: ILLEGAL_OP_DETECT_EN adds a sticky illegal_o flag.
module pipeline_control
  import pipeline_control_pkg::*;
#(
  parameter int ALU_OP_WIDTH = 3,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [6:0]                OP_i,
  input  logic [REG_ADDR_WIDTH-1:0] rs1_i,
  input  logic [REG_ADDR_WIDTH-1:0] rs2_i,
  input  logic [REG_ADDR_WIDTH-1:0] rd_i,
  input  logic                      id_valid_i,
  input  logic                      flush_i,
  output logic                      stall_o,
  output logic                      Branch_ex_o,
  output logic                      Jump_ex_o,
  output logic                      ALU_Src_ex_o,
  output logic [ALU_OP_WIDTH-1:0]   ALU_Op_ex_o,
  output logic [REG_ADDR_WIDTH-1:0] ex_rd_o,
  output logic                      Branch_mem_o,
  output logic                      Jump_mem_o,
  output logic                      Mem_Read_mem_o,
  output logic                      Mem_Write_mem_o,
  output logic [REG_ADDR_WIDTH-1:0] mem_rd_o,
`ifdef ILLEGAL_OP_DETECT_EN
  output logic                      illegal_o,
`endif
  output logic                      Reg_Write_wb_o,
  output logic                      Mem_to_Reg_wb_o,
  output logic [REG_ADDR_WIDTH-1:0] wb_rd_o
);

  localparam logic [REG_ADDR_WIDTH-1:0] RD_ZERO = {REG_ADDR_WIDTH{1'b0}};
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_ZERO = {ALU_OP_WIDTH{1'b0}};

  ctrl_t                     dec_ctrl_s;
  ctrl_t                     id_ctrl_s;
  logic [ALU_OP_WIDTH-1:0]   dec_alu_op_s;
  logic                      stall_s;
  logic                      id_capture_s;

  logic                      ex_valid_r;
  ctrl_t                     ex_ctrl_r;
  logic [ALU_OP_WIDTH-1:0]   ex_alu_op_r;
  logic [REG_ADDR_WIDTH-1:0] ex_rd_r;
  mem_ctrl_t                 mem_ctrl_r;
  logic [REG_ADDR_WIDTH-1:0] mem_rd_r;
  wb_ctrl_t                  wb_ctrl_r;
  logic [REG_ADDR_WIDTH-1:0] wb_rd_r;

`ifdef ILLEGAL_OP_DETECT_EN
  logic dec_illegal_s;
  logic illegal_r;
`endif

  control_decoder #(
    .ALU_OP_WIDTH(ALU_OP_WIDTH)
  ) u_decoder (
    .op_i     (OP_i),
    .ctrl_o   (dec_ctrl_s),
`ifdef ILLEGAL_OP_DETECT_EN
    .illegal_o(dec_illegal_s),
`endif
    .alu_op_o (dec_alu_op_s)
  );

  // Writes to x0 are architecturally void, so drop RegWrite before capture
  always_comb begin
    id_ctrl_s = dec_ctrl_s;
    if (rd_i == RD_ZERO) begin
      id_ctrl_s.reg_write = 1'b0;
    end else begin
      id_ctrl_s.reg_write = dec_ctrl_s.reg_write;
    end
  end

  // Load-use hazard against the load currently in EX; a flush overrides it
  always_comb begin
    if (id_valid_i && ex_valid_r && ex_ctrl_r.mem_read && (ex_rd_r != RD_ZERO) &&
        ((ex_rd_r == rs1_i) || (ex_rd_r == rs2_i)) && !flush_i) begin
      stall_s = 1'b1;
    end else begin
      stall_s = 1'b0;
    end
  end

  assign id_capture_s = id_valid_i & ~stall_s & ~flush_i;

  // ID/EX register: real instruction or an all-zero bubble
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_valid_r <= 1'b0;
      ex_ctrl_r <= CTRL_ZERO;
      ex_alu_op_r <= ALU_OP_ZERO;
      ex_rd_r <= RD_ZERO;
    end else if (id_capture_s) begin
      ex_valid_r <= 1'b1;
      ex_ctrl_r <= id_ctrl_s;
      ex_alu_op_r <= dec_alu_op_s;
      ex_rd_r <= rd_i;
    end else begin
      ex_valid_r <= 1'b0;
      ex_ctrl_r <= CTRL_ZERO;
      ex_alu_op_r <= ALU_OP_ZERO;
      ex_rd_r <= RD_ZERO;
    end
  end

  // EX/MEM register: the instruction in EX is killed by a flush
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_ctrl_r <= MEM_CTRL_ZERO;
      mem_rd_r <= RD_ZERO;
    end else if (flush_i) begin
      mem_ctrl_r <= MEM_CTRL_ZERO;
      mem_rd_r <= RD_ZERO;
    end else begin
      mem_ctrl_r <= '{branch:     ex_ctrl_r.branch,
                      jump:       ex_ctrl_r.jump,
                      mem_read:   ex_ctrl_r.mem_read,
                      mem_write:  ex_ctrl_r.mem_write,
                      reg_write:  ex_ctrl_r.reg_write,
                      mem_to_reg: ex_ctrl_r.mem_to_reg};
      mem_rd_r <= ex_rd_r;
    end
  end

  // MEM/WB register: the flushing instruction itself always retires
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wb_ctrl_r <= 2'b00;
      wb_rd_r <= RD_ZERO;
    end else begin
      wb_ctrl_r <= '{reg_write: mem_ctrl_r.reg_write, mem_to_reg: mem_ctrl_r.mem_to_reg};
      wb_rd_r <= mem_rd_r;
    end
  end

`ifdef ILLEGAL_OP_DETECT_EN
  // Sticky flag for an unknown opcode that actually enters the pipeline
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      illegal_r <= 1'b0;
    end else if (id_capture_s && dec_illegal_s) begin
      illegal_r <= 1'b1;
    end else begin
      illegal_r <= illegal_r;
    end
  end

  assign illegal_o = illegal_r;
`endif

  assign stall_o = stall_s;
  assign Branch_ex_o = ex_ctrl_r.branch;
  assign Jump_ex_o = ex_ctrl_r.jump;
  assign ALU_Src_ex_o = ex_ctrl_r.alu_src;
  assign ALU_Op_ex_o = ex_alu_op_r;
  assign ex_rd_o = ex_rd_r;
  assign Branch_mem_o = mem_ctrl_r.branch;
  assign Jump_mem_o = mem_ctrl_r.jump;
  assign Mem_Read_mem_o = mem_ctrl_r.mem_read;
  assign Mem_Write_mem_o = mem_ctrl_r.mem_write;
  assign mem_rd_o = mem_rd_r;
  assign Reg_Write_wb_o = wb_ctrl_r.reg_write;
  assign Mem_to_Reg_wb_o = wb_ctrl_r.mem_to_reg;
  assign wb_rd_o = wb_rd_r;

endmodule

// File: tb/tb_pipeline_control.sv
// Directed self-checking bench for pipeline_control.
module tb_pipeline_control;

  logic       clk;
  logic       reset;
  logic [6:0] OP_i;
  logic [4:0] rs1_i, rs2_i, rd_i;
  logic       id_valid_i, flush_i;
  logic       stall_o;
  logic       Branch_ex_o, Jump_ex_o, ALU_Src_ex_o;
  logic [2:0] ALU_Op_ex_o;
  logic [4:0] ex_rd_o;
  logic       Branch_mem_o, Jump_mem_o, Mem_Read_mem_o, Mem_Write_mem_o;
  logic [4:0] mem_rd_o;
  logic       Reg_Write_wb_o, Mem_to_Reg_wb_o;
  logic [4:0] wb_rd_o;
`ifdef ILLEGAL_OP_DETECT_EN
  logic       illegal_o;
`endif

  int pass_cnt = 0;
  int total_cnt = 0;

  pipeline_control dut (
    .clk(clk), .reset(reset), .OP_i(OP_i), .rs1_i(rs1_i), .rs2_i(rs2_i), .rd_i(rd_i),
    .id_valid_i(id_valid_i), .flush_i(flush_i), .stall_o(stall_o),
    .Branch_ex_o(Branch_ex_o), .Jump_ex_o(Jump_ex_o), .ALU_Src_ex_o(ALU_Src_ex_o),
    .ALU_Op_ex_o(ALU_Op_ex_o), .ex_rd_o(ex_rd_o),
    .Branch_mem_o(Branch_mem_o), .Jump_mem_o(Jump_mem_o), .Mem_Read_mem_o(Mem_Read_mem_o),
    .Mem_Write_mem_o(Mem_Write_mem_o), .mem_rd_o(mem_rd_o),
`ifdef ILLEGAL_OP_DETECT_EN
    .illegal_o(illegal_o),
`endif
    .Reg_Write_wb_o(Reg_Write_wb_o), .Mem_to_Reg_wb_o(Mem_to_Reg_wb_o), .wb_rd_o(wb_rd_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [10:0] ex_vec();
    return {Branch_ex_o, Jump_ex_o, ALU_Src_ex_o, ALU_Op_ex_o, ex_rd_o};
  endfunction
  function automatic logic [8:0] mem_vec();
    return {Branch_mem_o, Jump_mem_o, Mem_Read_mem_o, Mem_Write_mem_o, mem_rd_o};
  endfunction
  function automatic logic [6:0] wb_vec();
    return {Reg_Write_wb_o, Mem_to_Reg_wb_o, wb_rd_o};
  endfunction

  task automatic drive(input logic [6:0] op, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic v, input logic fl);
    OP_i = op; rs1_i = rs1; rs2_i = rs2; rd_i = rd; id_valid_i = v; flush_i = fl;
    #1;
  endtask

  task automatic bubble();
    drive(7'b0000000, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bubble();
    tick();
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    total_cnt++;
    if ({ex_vec(), mem_vec(), wb_vec(), stall_o} !== 28'd0) begin
      $display("FAIL reset_outputs: got %h expected 0", {ex_vec(), mem_vec(), wb_vec(), stall_o});
    end else pass_cnt++;
  endtask

  task automatic test_rtype();
    drive(7'b0110011, 5'd1, 5'd2, 5'd5, 1'b1, 1'b0);
    tick();
    total_cnt++;
    if ({ALU_Op_ex_o, ALU_Src_ex_o, ex_rd_o} !== {3'b000, 1'b0, 5'd5}) begin
      $display("FAIL rtype_ex: got op=%b src=%b rd=%0d expected op=000 src=0 rd=5",
               ALU_Op_ex_o, ALU_Src_ex_o, ex_rd_o);
    end else pass_cnt++;
    bubble();
    tick();
    tick();
    total_cnt++;
    if (wb_vec() !== {1'b1, 1'b0, 5'd5}) begin
      $display("FAIL rtype_wb: got %b expected %b", wb_vec(), {1'b1, 1'b0, 5'd5});
    end else pass_cnt++;
  endtask

  // {branch,jump,mem_read,mem_write,reg_write,mem_to_reg,alu_src,alu_op[2:0]}
  task automatic test_decode();
    logic [6:0] ops [11];
    logic [9:0] exp [11];
    ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b0110111,
            7'b0010111, 7'b1101111, 7'b1100111, 7'b1111111, 7'b0000000};
    exp = '{10'b0000100000, 10'b0000101001, 10'b0010111010, 10'b0001001010,
            10'b1000000011, 10'b0000101100, 10'b0000101101, 10'b0100100110,
            10'b0100101110, 10'b0000000000, 10'b0000000000};
    for (int i = 0; i < 11; i++) begin
      logic [9:0] e;
      e = exp[i];
      drive(ops[i], 5'd0, 5'd0, 5'd1, 1'b1, 1'b0);
      tick();
      total_cnt++;
      if ({Branch_ex_o, Jump_ex_o, ALU_Src_ex_o, ALU_Op_ex_o} !== {e[9], e[8], e[3], e[2:0]}) begin
        $display("FAIL decode_ex[%0d]: got %b expected %b", i,
                 {Branch_ex_o, Jump_ex_o, ALU_Src_ex_o, ALU_Op_ex_o}, {e[9], e[8], e[3], e[2:0]});
      end else pass_cnt++;
      bubble();
      tick();
      total_cnt++;
      if ({Branch_mem_o, Jump_mem_o, Mem_Read_mem_o, Mem_Write_mem_o} !== e[9:6]) begin
        $display("FAIL decode_mem[%0d]: got %b expected %b", i,
                 {Branch_mem_o, Jump_mem_o, Mem_Read_mem_o, Mem_Write_mem_o}, e[9:6]);
      end else pass_cnt++;
      tick();
      total_cnt++;
      if ({Reg_Write_wb_o, Mem_to_Reg_wb_o} !== e[5:4]) begin
        $display("FAIL decode_wb[%0d]: got %b expected %b", i, {Reg_Write_wb_o, Mem_to_Reg_wb_o}, e[5:4]);
      end else pass_cnt++;
    end
  endtask

  task automatic test_load_use();
    do_reset();
    drive(7'b0000011, 5'd0, 5'd0, 5'd7, 1'b1, 1'b0);
    tick();
    drive(7'b0110011, 5'd7, 5'd0, 5'd3, 1'b1, 1'b0);
    total_cnt++;
    if (stall_o !== 1'b1) $display("FAIL load_use_stall: got %b expected 1", stall_o);
    else pass_cnt++;
    tick();
    total_cnt++;
    if ({stall_o, ex_vec()} !== 12'd0) $display("FAIL load_use_bubble: got %h expected 0", {stall_o, ex_vec()});
    else pass_cnt++;
    total_cnt++;
    if ({Mem_Read_mem_o, mem_rd_o} !== {1'b1, 5'd7}) $display("FAIL load_use_mem: got %b expected %b", {Mem_Read_mem_o, mem_rd_o}, {1'b1, 5'd7});
    else pass_cnt++;
    tick();
    total_cnt++;
    if (ex_vec() !== {1'b0, 1'b0, 1'b0, 3'b000, 5'd3}) $display("FAIL load_use_ex: got %b expected rd=3", ex_vec());
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int stalls;
    do_reset();
    stalls = 0;
    drive(7'b0000011, 5'd0, 5'd0, 5'd7, 1'b1, 1'b0);
    tick();
    drive(7'b0000011, 5'd7, 5'd0, 5'd8, 1'b1, 1'b0);
    for (int c = 0; c < 4 && ex_rd_o != 5'd8; c++) begin
      if (stall_o) stalls++;
      tick();
    end
    drive(7'b0110011, 5'd0, 5'd8, 5'd9, 1'b1, 1'b0);
    for (int c = 0; c < 4 && ex_rd_o != 5'd9; c++) begin
      if (stall_o) stalls++;
      tick();
    end
    total_cnt++;
    if (stalls != 2) $display("FAIL b2b_stall_count: got %0d expected 2", stalls);
    else pass_cnt++;
    total_cnt++;
    if (ex_rd_o !== 5'd9) $display("FAIL b2b_consumer_ex: got %0d expected 9", ex_rd_o);
    else pass_cnt++;
  endtask

  task automatic test_rd_zero();
    do_reset();
    drive(7'b0000011, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
    tick();
    drive(7'b0110011, 5'd0, 5'd0, 5'd4, 1'b1, 1'b0);
    total_cnt++;
    if (stall_o !== 1'b0) $display("FAIL rd0_stall: got %b expected 0", stall_o);
    else pass_cnt++;
    tick();
    bubble();
    tick();
    total_cnt++;
    if (wb_vec() !== {1'b0, 1'b1, 5'd0}) $display("FAIL rd0_wb: got %b expected %b", wb_vec(), {1'b0, 1'b1, 5'd0});
    else pass_cnt++;
  endtask

  task automatic test_flush();
    do_reset();
    drive(7'b0110011, 5'd0, 5'd0, 5'd5, 1'b1, 1'b0);
    tick();
    drive(7'b0000011, 5'd0, 5'd0, 5'd7, 1'b1, 1'b0);
    tick();
    drive(7'b0110011, 5'd7, 5'd0, 5'd3, 1'b1, 1'b1);
    total_cnt++;
    if (stall_o !== 1'b0) $display("FAIL flush_stall: got %b expected 0", stall_o);
    else pass_cnt++;
    tick();
    total_cnt++;
    if ({ex_vec(), mem_vec()} !== 20'd0) $display("FAIL flush_ex_mem: got %h expected 0", {ex_vec(), mem_vec()});
    else pass_cnt++;
    total_cnt++;
    if (wb_vec() !== {1'b1, 1'b0, 5'd5}) $display("FAIL flush_wb: got %b expected %b", wb_vec(), {1'b1, 1'b0, 5'd5});
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    drive(7'b0110011, 5'd0, 5'd0, 5'd5, 1'b1, 1'b0);
    tick();
    drive(7'b0010011, 5'd0, 5'd0, 5'd6, 1'b1, 1'b0);
    tick();
    drive(7'b0000011, 5'd0, 5'd0, 5'd7, 1'b1, 1'b0);
    tick();
    drive(7'b0110011, 5'd7, 5'd0, 5'd10, 1'b1, 1'b0);
    #1;
    reset = 1'b1;
    #1;
    total_cnt++;
    if ({ex_vec(), mem_vec(), wb_vec(), stall_o} !== 28'd0) begin
      $display("FAIL reset_mid_async: got %h expected 0", {ex_vec(), mem_vec(), wb_vec(), stall_o});
    end else pass_cnt++;
    tick();
    reset = 1'b0;
    #1;
    tick();
    total_cnt++;
    if ({ex_vec(), mem_vec(), wb_vec()} !== {1'b0, 1'b0, 1'b0, 3'b000, 5'd10, 9'd0, 7'd0}) begin
      $display("FAIL reset_mid_first_capture: got %h expected ex rd=10 only", {ex_vec(), mem_vec(), wb_vec()});
    end else pass_cnt++;
  endtask

`ifdef ILLEGAL_OP_DETECT_EN
  task automatic test_illegal();
    do_reset();
    total_cnt++;
    if (illegal_o !== 1'b0) $display("FAIL illegal_reset: got %b expected 0", illegal_o);
    else pass_cnt++;
    drive(7'b1111111, 5'd0, 5'd0, 5'd1, 1'b1, 1'b0);
    tick();
    total_cnt++;
    if (illegal_o !== 1'b1) $display("FAIL illegal_set: got %b expected 1", illegal_o);
    else pass_cnt++;
    drive(7'b0110011, 5'd0, 5'd0, 5'd2, 1'b1, 1'b0);
    tick();
    tick();
    total_cnt++;
    if (illegal_o !== 1'b1) $display("FAIL illegal_sticky: got %b expected 1", illegal_o);
    else pass_cnt++;
    do_reset();
    total_cnt++;
    if (illegal_o !== 1'b0) $display("FAIL illegal_clear: got %b expected 0", illegal_o);
    else pass_cnt++;
  endtask
`endif

  initial begin
    reset = 1'b1;
    OP_i = 7'd0; rs1_i = 5'd0; rs2_i = 5'd0; rd_i = 5'd0;
    id_valid_i = 1'b0; flush_i = 1'b0;
    test_reset();
    test_rtype();
    test_decode();
    test_load_use();
    test_back_to_back();
    test_rd_zero();
    test_flush();
    test_reset_mid();
`ifdef ILLEGAL_OP_DETECT_EN
    test_illegal();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/pipeline_control.md
PIPELINE_CONTROL -- requirements
Module: pipeline_control

Interface
REQ-001 Parameter ALU_OP_WIDTH, default 3, width of the ALU operation code (SHALL be >= 3).
REQ-002 Parameter REG_ADDR_WIDTH, default 5, width of the register-index fields.
REQ-003 Port clk, input, 1, sole clock; all state SHALL update on its rising edge.
REQ-004 Port reset, input, 1, asynchronous active-high reset.
REQ-005 Port OP_i, input, 7, opcode of the instruction in ID.
REQ-006 Ports rs1_i, rs2_i, rd_i, input, REG_ADDR_WIDTH, register indices of the instruction in ID.
REQ-007 Port id_valid_i, input, 1, the ID instruction is real (not a bubble).
REQ-008 Port flush_i, input, 1, taken-branch or jump kill from MEM.
REQ-009 Port stall_o, output, 1, load-use hazard; upstream SHALL hold PC and IF/ID.
REQ-010 Ports Branch_ex_o, Jump_ex_o, ALU_Src_ex_o (1 each), ALU_Op_ex_o (ALU_OP_WIDTH), ex_rd_o (REG_ADDR_WIDTH), outputs, EX-stage control.
REQ-011 Ports Branch_mem_o, Jump_mem_o, Mem_Read_mem_o, Mem_Write_mem_o (1 each), mem_rd_o (REG_ADDR_WIDTH), outputs, MEM-stage control.
REQ-012 Ports Reg_Write_wb_o, Mem_to_Reg_wb_o (1 each), wb_rd_o (REG_ADDR_WIDTH), outputs, WB-stage control.

Function
REQ-013 Decode SHALL be combinational from OP_i: R 0110011 -> RegWrite, ALUOp 000; I-logic 0010011 -> RegWrite, ALUSrc, 001; load 0000011 -> MemRead, MemToReg, RegWrite, ALUSrc, 010; store 0100011 -> MemWrite, ALUSrc, 010; branch 1100011 -> Branch, 011; LUI 0110111 -> RegWrite, ALUSrc, 100; AUIPC 0010111 -> RegWrite, ALUSrc, 101; JAL 1101111 -> Jump, RegWrite, 110; JALR 1100111 -> Jump, RegWrite, ALUSrc, 110; any other -> all zero.
REQ-014 ALU_Op codes SHALL be zero-extended to ALU_OP_WIDTH.
REQ-015 RegWrite SHALL be forced 0 at ID/EX capture when rd_i == 0.
REQ-016 Bundle pipeline: ID/EX -> EX/MEM -> MEM/WB, one register each; an instruction's control appears at EX, MEM, WB outputs 1, 2, 3 cycles after ID capture.
REQ-017 stall_o = id_valid_i & ex_valid & ex MemRead & ex_rd != 0 & (ex_rd == rs1_i | ex_rd == rs2_i) & ~flush_i, combinational from registered EX state.
REQ-018 ID/EX SHALL capture an all-zero bubble (valid 0) when stall_o, flush_i or ~id_valid_i; otherwise the decoded bundle with valid 1.
REQ-019 EX/MEM SHALL capture zeros when flush_i, else ID/EX contents; MEM/WB SHALL always capture EX/MEM contents.
REQ-020 Simultaneous flush_i and hazard: flush wins, stall_o = 0, bubble inserted.
REQ-021 Back-to-back loads feeding a consumer SHALL stall exactly one cycle per hazard; a stall never exceeds one cycle for a given ID instruction.

Reset
REQ-022 Reset SHALL clear all three stage registers (valid, control, rd) to 0 immediately; all outputs 0, stall_o 0.
REQ-023 Reset asserted mid-stream SHALL discard in-flight instructions; the first post-reset capture SHALL behave as from power-up.

Configuration
REQ-024 Macro ILLEGAL_OP_DETECT_EN defined: output illegal_o (1 bit) exists, a sticky flag set at the clock edge where id_valid_i=1, stall_o=0, flush_i=0 and OP_i is not in REQ-013; cleared only by reset.
REQ-025 Macro undefined: illegal_o port and flag absent; illegal opcodes still decode to an all-zero bundle.

Structure
REQ-026 Package pipeline_control_pkg SHALL hold opcode constants, ALU_Op code constants and the control-bundle typedef.
REQ-027 Sub-module control_decoder SHALL implement REQ-013/REQ-014 combinationally, instantiated once.

Verification
REQ-028 R-type OP_i=0110011, rd=5, valid at T -> T+1 ALU_Op_ex_o=000, ALU_Src_ex_o=0; T+3 Reg_Write_wb_o=1, wb_rd_o=5.
REQ-029 Load rd=7 at T, then R-type rs1=7 at T+1 -> stall_o=1 during T+1 only; EX bubble at T+2; R-type in EX at T+3.
REQ-030 Load rd=0 then consumer rs1=0 -> stall_o stays 0; load's Reg_Write_wb_o=0.
REQ-031 flush_i=1 coincident with a load-use hazard -> stall_o=0; next cycle EX and MEM outputs all 0; WB shows the older instruction.
REQ-032 Reset pulse mid-stream with three valid instructions in flight -> all outputs 0 at once and at first post-reset edge.
REQ-033 ILLEGAL_OP_DETECT_EN defined, OP_i=1111111 valid -> illegal_o=1 next cycle, held through further legal ops until reset; undefined -> zero bundle, no port.
